// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated single-port data memory responder with optional per-word parity (DMEM_PARITY_EN)
// Ports: clk, reset (sync, active-high); req/we/addr/wdata/pinj request fields sampled in IDLE;
//        busy (WAIT/RESP), ack (one-cycle completion), rdata (read data), perr (parity error on read ack).
module dmem_responder #(
  parameter int DWIDTH = 4,
  parameter int AWIDTH = 4,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              pinj,
  output logic              busy,
  output logic              ack,
  output logic [DWIDTH-1:0] rdata,
  output logic              perr
);
  localparam int DEPTH = 2 ** AWIDTH;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t            state_q;
  logic [2:0]        cnt_q;
  logic              busy_q, ack_q, we_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] wdata_q, rdata_q;
  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic              go_we;
  logic [AWIDTH-1:0] go_addr;
  // Fields of the access about to enter RESP: live inputs on the zero-wait path, latched otherwise.
  always_comb begin
    go_we   = (state_q == S_IDLE) ? we : we_q;
    go_addr = (state_q == S_IDLE) ? addr : addr_q;
  end
  assign busy  = busy_q;
  assign ack   = ack_q;
  assign rdata = rdata_q;
`ifdef DMEM_PARITY_EN
  logic             pinj_q, perr_q;
  logic [DEPTH-1:0] par_q;
  logic             go_perr;
  assign go_perr = par_q[go_addr] ^ (^mem_q[go_addr]);
  assign perr    = perr_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pinj_q <= 1'b0;
      perr_q <= 1'b0;
      par_q  <= '0;
    end else begin
      perr_q <= 1'b0;
      if (state_q == S_IDLE && req) pinj_q <= pinj;
      if (((state_q == S_IDLE && req && WAIT == 0) || (state_q == S_WAIT && cnt_q == 3'd1)) && !go_we)
        perr_q <= go_perr;
      if (state_q == S_RESP && we_q) par_q[addr_q] <= (^wdata_q) ^ pinj_q;
    end
  end
`else
  logic unused_pinj;
  assign unused_pinj = pinj;
  assign perr        = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
          cnt_q   <= 3'(WAIT);
          busy_q  <= 1'b1;
          if (WAIT == 0) begin
            state_q <= S_RESP;
            ack_q   <= 1'b1;
            if (!go_we) rdata_q <= mem_q[go_addr];
          end else state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_q <= S_RESP;
            ack_q   <= 1'b1;
            if (!go_we) rdata_q <= mem_q[go_addr];
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          if (we_q) mem_q[addr_q] <= wdata_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DWIDTH, default 4, data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 4, word address width; depth = 2**AWIDTH words.
REQ-003 SHALL have parameter WAIT, default 2, number of wait-state cycles per access (0..7).
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  1  initiator request; sampled only in IDLE.
REQ-007 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 SHALL have port addr  input  AWIDTH  word address; sampled with req.
REQ-009 SHALL have port wdata  input  DWIDTH  write data; sampled with req.
REQ-010 SHALL have port pinj  input  1  parity-inject; sampled with req on writes.
REQ-011 SHALL have port busy  output  1  high in WAIT and RESP.
REQ-012 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-013 SHALL have port rdata  output  DWIDTH  read data, valid when ack is high for a read.
REQ-014 SHALL have port perr  output  1  parity-error flag, valid with ack.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-016 IDLE with req=1: SHALL latch we/addr/wdata/pinj, load wait counter with WAIT, and go to WAIT (WAIT>0) or RESP (WAIT=0).
REQ-017 IDLE with req=0: SHALL remain in IDLE; busy=0, ack=0.
REQ-018 WAIT: SHALL decrement counter each cycle; on the cycle counter reaches 1, SHALL go to RESP.
REQ-019 RESP: SHALL assert ack for exactly one cycle, perform the access on the latched fields, and return to IDLE.
REQ-020 Latency: ack SHALL rise WAIT+1 cycles after the cycle req is sampled in IDLE.
REQ-021 Write: SHALL commit wdata to mem[addr] at the RESP clock edge; rdata SHALL be unchanged.
REQ-022 Read: rdata SHALL equal mem[addr] during the ack cycle and hold until the next read ack.
REQ-023 req/we/addr/wdata changes while busy=1 SHALL be ignored; no queuing.
REQ-024 req held high continuously SHALL start a new access in the IDLE cycle after each ack (throughput one access per WAIT+2 cycles).
REQ-025 Read to an address written by the immediately preceding access SHALL return the new data.
REQ-026 Address SHALL be used modulo 2**AWIDTH; no out-of-range case exists.
REQ-027 perr SHALL be 0 whenever ack=0 and on every write ack.

Reset
REQ-028 reset=1 SHALL force IDLE, counter=0, busy=0, ack=0, perr=0, rdata=0 on the next edge.
REQ-029 reset SHALL clear every memory word (and parity bit) to 0.
REQ-030 reset during WAIT or RESP SHALL abort the access; no write commits, no ack is issued.
REQ-031 reset SHALL take priority over req in the same cycle.

Configuration
REQ-032 Macro DMEM_PARITY_EN SHALL compile in one even-parity bit per word.
REQ-033 With DMEM_PARITY_EN: a write SHALL store ^wdata XOR pinj; a read ack SHALL drive perr=1 when the stored bit differs from ^mem[addr].
REQ-034 Without DMEM_PARITY_EN: no parity storage; perr SHALL be tied 0; pinj SHALL be ignored; all ports remain present.

Verification
REQ-035 Reset then idle: reset 1 cycle, req=0 for 5 cycles -> busy=0, ack=0, rdata=0, perr=0 throughout.
REQ-036 Write/read, WAIT=2: write addr=3 data=0xA, then read addr=3 -> each ack exactly 3 cycles after req sampled; read ack shows rdata=0xA.
REQ-037 Busy rejection: during a WAIT of write addr=5 data=0x1, drive req with we=1 addr=6 data=0xF -> addr=6 still reads 0x0 and addr=5 reads 0x1.
REQ-038 Back-to-back, WAIT=0: req held high, write addr=0xF data=0x7, then read addr=0xF -> acks every 2 cycles; read returns 0x7.
REQ-039 Reset mid-op: start write addr=2 data=0x9, assert reset in WAIT -> no ack; subsequent read addr=2 returns 0x0.
REQ-040 Parity (DMEM_PARITY_EN): write addr=1 data=0x3 pinj=1, read addr=1 -> rdata=0x3, perr=1; rewrite with pinj=0 and read -> perr=0; without macro both reads show perr=0.
